// File: rtl/hist_pkg.sv
// hist_pkg: shared constants and FSM encoding for the histogram-equalization pipeline
package hist_pkg;
  localparam int PIX_W   = 8;
  localparam int W_DEF   = 960;
  localparam int H_DEF   = 540;
  localparam int FNW_DEF = 16;
  typedef enum logic {WAIT_SOP = 1'b0, IN_FRAME = 1'b1} state_t;
endpackage

// File: rtl/hist_if.sv
// hist_if: pixel stream in, tagged pixel stream out, plus frame status
interface hist_if #(
  parameter int XW  = 11,
  parameter int YW  = 10,
  parameter int FNW = hist_pkg::FNW_DEF
) ();
  logic [hist_pkg::PIX_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [hist_pkg::PIX_W-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_sop;
  logic                       out_eop;
  logic [XW-1:0]              out_x;
  logic [YW-1:0]              out_y;
  logic                       sync_clr;
  logic [FNW-1:0]             frame_num;
  logic                       frame_done;
  modport slave (
    input  in_data, in_valid, out_ready, sync_clr,
    output in_ready, out_data, out_valid, out_sop, out_eop, out_x, out_y, frame_num, frame_done
  );
  modport master (
    output in_data, in_valid, out_ready, sync_clr,
    input  in_ready, out_data, out_valid, out_sop, out_eop, out_x, out_y, frame_num, frame_done
  );
endinterface

// File: rtl/hist_skid2.sv
// hist_skid2: 2-entry skid buffer; ready and valid come straight from the occupancy register
module hist_skid2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    count
);
  logic [DW-1:0] d0, d1;
  logic wr, rd;
  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign out_data  = d0;
  assign wr = in_valid & in_ready;
  assign rd = out_valid & out_ready;
  // d0 is always the oldest entry; a read shifts d1 (or the incoming beat) into it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      d0    <= '0;
      d1    <= '0;
    end else begin
      count <= count + {1'b0, wr} - {1'b0, rd};
      if (rd) d0 <= (wr && count == 2'd1) ? in_data : d1;
      else if (wr && count == 2'd0) d0 <= in_data;
      if (wr && !rd && count == 2'd1) d1 <= in_data;
    end
  end
endmodule

// File: rtl/hist_framer.sv
// hist_framer: buffers the raw pixel stream and tags each output beat with raster position and frame markers
module hist_framer import hist_pkg::*; #(
  parameter int W   = W_DEF,
  parameter int H   = H_DEF,
  parameter int XW  = 11,
  parameter int YW  = 10,
  parameter int FNW = FNW_DEF
) (
  input logic   clk,
  input logic   rst,
  hist_if.slave bus
);
  logic [1:0]     occ;
  logic           vld, at_xe, at_ye, xfer, eop_xfer;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [FNW-1:0] fn;
  logic           done;
  state_t         state, state_nx;
  hist_skid2 #(.DW(PIX_W)) skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (bus.in_data),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .out_data (bus.out_data),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .count    (occ)
  );
  assign vld      = occ != 2'd0;
  assign at_xe    = x == XW'(W - 1);
  assign at_ye    = y == YW'(H - 1);
  assign xfer     = bus.out_valid & bus.out_ready;
  assign eop_xfer = xfer & at_xe & at_ye;
  assign bus.out_x      = x;
  assign bus.out_y      = y;
  assign bus.out_sop    = vld & (x == '0) & (y == '0);
  assign bus.out_eop    = vld & at_xe & at_ye;
  assign bus.frame_num  = fn;
  assign bus.frame_done = done;
  // raster counters step on each output transfer; sync_clr wins but the current beat keeps its tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (bus.sync_clr) begin
      x <= '0;
      y <= '0;
    end else if (xfer) begin
      x <= at_xe ? '0 : x + 1'b1;
      if (at_xe) y <= at_ye ? '0 : y + 1'b1;
    end
  end
  // frame counter and done pulse follow every eop transfer, even one coinciding with sync_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fn   <= '0;
      done <= 1'b0;
    end else begin
      fn   <= fn + FNW'(eop_xfer);
      done <= eop_xfer;
    end
  end
  // control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_SOP;
    else      state <= state_nx;
  end
  // frame tracking: enter on a sop transfer, leave on an eop transfer or resync
  always_comb begin
    state_nx = state;
    state_nx = bus.sync_clr                                 ? WAIT_SOP :
               (state == WAIT_SOP && xfer && bus.out_sop)  ? IN_FRAME :
               (state == IN_FRAME && eop_xfer)             ? WAIT_SOP : state;
  end
endmodule
